// File: rtl/serpent_pkg.sv
// Shared Serpent constants, subkey array type and the S-box / linear-transform primitives.
// Block word i sits at bits [32*i +: 32]; key word i sits at key bits [32*i +: 32].
package serpent_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 256;
    localparam int NROUNDS = 32;

    localparam logic [31:0] PHI = 32'h9e37_79b9;

    typedef logic [NROUNDS:0][BLOCK_W-1:0] subkeys_t;

    // Nibble n of box b lives at SBOX_TAB[b][4*n +: 4].
    localparam logic [7:0][63:0] SBOX_TAB = {
        64'h6539_AC47_B28E_0FD1,
        64'h0A3D_F19E_B648_5C27,
        64'h176D_8E30_C9A4_B25F,
        64'hD7E9_A452_6B0C_38F1,
        64'hE57A_421D_369C_8BF0,
        64'h25B0_4E1D_FAC3_9768,
        64'h43D6_8EB1_A509_72CF,
        64'hC907_24DE_B56A_1F83
    };

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Bitsliced S-box: bit j of the four words forms one 4-bit column.
    function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [2:0] idx,
                                                      input logic [BLOCK_W-1:0] x);
        logic [63:0]        tab;
        logic [3:0]         nib;
        logic [3:0]         o;
        logic [BLOCK_W-1:0] y;
        tab = SBOX_TAB[idx];
        y   = '0;
        for (int j = 0; j < 32; j++) begin
            nib       = {x[96+j], x[64+j], x[32+j], x[j]};
            o         = tab[{nib, 2'b00} +: 4];
            y[j]      = o[0];
            y[32+j]   = o[1];
            y[64+j]   = o[2];
            y[96+j]   = o[3];
        end
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] linear_transform(input logic [BLOCK_W-1:0] x);
        logic [31:0] x0, x1, x2, x3;
        x0 = x[31:0];
        x1 = x[63:32];
        x2 = x[95:64];
        x3 = x[127:96];
        x0 = rotl32(x0, 13);
        x2 = rotl32(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rotl32(x1, 1);
        x3 = rotl32(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rotl32(x0, 5);
        x2 = rotl32(x2, 22);
        return {x3, x2, x1, x0};
    endfunction

    function automatic subkeys_t key_schedule(input logic [KEY_W-1:0] k);
        logic [31:0] w [0:139];
        subkeys_t    sk;
        for (int i = 0; i < 8; i++) begin
            w[i] = k[32*i +: 32];
        end
        for (int i = 0; i < 132; i++) begin
            w[i+8] = rotl32(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ PHI ^ 32'(i), 11);
        end
        // Subkey n uses S-box (3 - n) mod 8 over prekeys 4n..4n+3.
        for (int n = 0; n <= NROUNDS; n++) begin
            sk[n] = sbox_layer(3'((35 - n) % 8),
                               {w[8+4*n+3], w[8+4*n+2], w[8+4*n+1], w[8+4*n]});
        end
        return sk;
    endfunction

endpackage

// File: rtl/serpent_keys.sv
// Combinational Serpent key schedule: 256-bit user key to 33 round subkeys.
module serpent_keys
    import serpent_pkg::*;
(
    input  logic [KEY_W-1:0] key256,
    output subkeys_t         subkeys
);

    assign subkeys = key_schedule(key256);

endmodule

// File: rtl/serpent_round.sv
// One Serpent round: subkey mix, S-box R mod 8, then linear transform
// (or, for the last round, a mix with the final subkey).
module serpent_round
    import serpent_pkg::*;
#(
    parameter int R = 0
) (
    input  logic [BLOCK_W-1:0] x,
    input  logic [BLOCK_W-1:0] k,
    input  logic [BLOCK_W-1:0] k_last,
    output logic [BLOCK_W-1:0] y
);

    localparam logic [2:0] BOX = 3'(R % 8);

    logic [BLOCK_W-1:0] s;

    assign s = sbox_layer(BOX, x ^ k);
    assign y = (R == NROUNDS - 1) ? (s ^ k_last) : linear_transform(s);

endmodule

// File: rtl/serpent_encrypt_pipe.sv
// Fully pipelined Serpent-256 encryptor, RPS rounds per stage, one block per cycle.
// All channels are valid/ready: a transfer happens only on an edge where valid && ready.
module serpent_encrypt_pipe
    import serpent_pkg::*;
#(
    parameter int RPS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    localparam int STAGES = NROUNDS / RPS;

    if (!(RPS == 1 || RPS == 2 || RPS == 4 || RPS == 8)) begin : g_bad_rps
        $error("serpent_encrypt_pipe: RPS must be 1, 2, 4 or 8");
    end

    logic [KEY_W-1:0]   key_reg;
    logic               key_loaded;
    subkeys_t           subkeys;

    logic [BLOCK_W-1:0] in_q;
    logic               in_q_valid;
    logic [BLOCK_W-1:0] stage_data [STAGES];
    logic [STAGES-1:0]  stage_valid;
    logic [BLOCK_W-1:0] stage_next [STAGES];

    logic adv;
    logic key_fire;
    logic in_fire;

    // key_reg only changes while nothing is in flight, so subkeys are static per block.
    serpent_keys u_keys (
        .key256  (key_reg),
        .subkeys (subkeys)
    );

    assign busy      = in_q_valid | (|stage_valid);
    assign key_ready = !busy;
    assign key_fire  = key_valid && key_ready;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = key_loaded && adv && !key_fire;
    assign in_fire   = in_valid && in_ready;

    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [BLOCK_W-1:0] stage_in;

        if (s == 0) begin : g_src_in
            assign stage_in = in_q;
        end else begin : g_src_prev
            assign stage_in = stage_data[s-1];
        end

        for (genvar j = 0; j < RPS; j++) begin : g_round
            logic [BLOCK_W-1:0] x;
            logic [BLOCK_W-1:0] y;

            if (j == 0) begin : g_first
                assign x = stage_in;
            end else begin : g_chain
                assign x = g_round[j-1].y;
            end

            serpent_round #(.R(s * RPS + j)) u_round (
                .x      (x),
                .k      (subkeys[s * RPS + j]),
                .k_last (subkeys[NROUNDS]),
                .y      (y)
            );
        end

        assign stage_next[s] = g_round[RPS-1].y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg     <= '0;
            key_loaded  <= 1'b0;
            in_q        <= '0;
            in_q_valid  <= 1'b0;
            stage_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_data[s] <= '0;
            end
        end else begin
            if (key_fire) begin
                key_reg    <= key_in;
                key_loaded <= 1'b1;
            end
            // A stalled output freezes the whole pipe, data and valid alike.
            if (adv) begin
                in_q_valid  <= in_fire;
                if (in_fire) begin
                    in_q <= in_data;
                end
                stage_valid <= {stage_valid[STAGES-2:0], in_q_valid};
                for (int s = 0; s < STAGES; s++) begin
                    stage_data[s] <= stage_next[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_serpent_encrypt_pipe.sv
// Self-checking bench for serpent_encrypt_pipe against a word-level Serpent reference model.
module tb_serpent_encrypt_pipe;

    typedef logic [3:0][31:0] words_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         a_key_valid;
    logic [255:0] a_key_in;
    logic         a_in_valid;
    logic [127:0] a_in_data;
    logic         a1_key_ready, a4_key_ready, a8_key_ready;
    logic         a1_in_ready,  a4_in_ready,  a8_in_ready;
    logic         a1_out_valid, a4_out_valid, a8_out_valid;
    logic [127:0] a1_out_data,  a4_out_data,  a8_out_data;
    logic         a1_busy,      a4_busy,      a8_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] cur_key;
    logic [127:0] exp_q[$];

    localparam logic [255:0] KAT_KEY = {4{64'h0123_4567_89AB_CDEF}};

    // Clock / reset
    always #5 clk = ~clk;

    serpent_encrypt_pipe #(.RPS(2)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    serpent_encrypt_pipe #(.RPS(1)) dut_r1 (
        .clk(clk), .rst(rst),
        .key_valid(a_key_valid), .key_ready(a1_key_ready), .key_in(a_key_in),
        .in_valid(a_in_valid), .in_ready(a1_in_ready), .in_data(a_in_data),
        .out_valid(a1_out_valid), .out_ready(1'b1), .out_data(a1_out_data),
        .busy(a1_busy)
    );

    serpent_encrypt_pipe #(.RPS(4)) dut_r4 (
        .clk(clk), .rst(rst),
        .key_valid(a_key_valid), .key_ready(a4_key_ready), .key_in(a_key_in),
        .in_valid(a_in_valid), .in_ready(a4_in_ready), .in_data(a_in_data),
        .out_valid(a4_out_valid), .out_ready(1'b1), .out_data(a4_out_data),
        .busy(a4_busy)
    );

    serpent_encrypt_pipe #(.RPS(8)) dut_r8 (
        .clk(clk), .rst(rst),
        .key_valid(a_key_valid), .key_ready(a8_key_ready), .key_in(a_key_in),
        .in_valid(a_in_valid), .in_ready(a8_in_ready), .in_data(a_in_data),
        .out_valid(a8_out_valid), .out_ready(1'b1), .out_data(a8_out_data),
        .busy(a8_busy)
    );

    // Reference model: Serpent in its usual four-word bitsliced form.
    int sb_tab [8][16] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };

    function automatic logic [31:0] rol(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic words_t sbox_words(int box, words_t x);
        words_t y;
        int     n;
        int     v;
        y = '0;
        for (int j = 0; j < 32; j++) begin
            n = 0;
            if (x[0][j]) n += 1;
            if (x[1][j]) n += 2;
            if (x[2][j]) n += 4;
            if (x[3][j]) n += 8;
            v = sb_tab[box][n];
            for (int b = 0; b < 4; b++) begin
                y[b][j] = ((v >> b) & 1) == 1;
            end
        end
        return y;
    endfunction

    function automatic words_t lin(words_t x);
        words_t y;
        y    = x;
        y[0] = rol(y[0], 13);
        y[2] = rol(y[2], 3);
        y[1] = y[1] ^ y[0] ^ y[2];
        y[3] = y[3] ^ y[2] ^ (y[0] << 3);
        y[1] = rol(y[1], 1);
        y[3] = rol(y[3], 7);
        y[0] = y[0] ^ y[1] ^ y[3];
        y[2] = y[2] ^ y[3] ^ (y[1] << 7);
        y[0] = rol(y[0], 5);
        y[2] = rol(y[2], 22);
        return y;
    endfunction

    function automatic logic [127:0] ref_encrypt(logic [255:0] key, logic [127:0] pt);
        logic [31:0] w [140];
        words_t      sk [33];
        words_t      t;
        words_t      x;
        for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
        for (int i = 0; i < 132; i++)
            w[i+8] = rol(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9e37_79b9 ^ 32'(i), 11);
        for (int n = 0; n < 33; n++) begin
            for (int b = 0; b < 4; b++) t[b] = w[8 + 4*n + b];
            sk[n] = sbox_words((35 - n) % 8, t);
        end
        x = pt;
        for (int r = 0; r < 32; r++) begin
            x = x ^ sk[r];
            x = sbox_words(r % 8, x);
            if (r < 31) x = lin(x);
            else        x = x ^ sk[32];
        end
        return x;
    endfunction

    // Scoreboard check
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver tasks: each starts and ends just after a falling edge.
    task automatic do_reset();
        rst         = 1'b1;
        key_valid   = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a_key_valid = 1'b0;
        a_in_valid  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_key(input logic [255:0] k);
        logic got;
        got       = 1'b0;
        key_valid = 1'b1;
        key_in    = k;
        for (int c = 0; c < 200; c++) begin
            #1;
            got = key_ready;
            @(negedge clk);
            if (got) break;
        end
        key_valid = 1'b0;
        cur_key   = k;
        check("key_load_accepted", 128'(got), 128'(1));
    endtask

    task automatic send_and_check(input logic [127:0] d, input string tag);
        logic         sent;
        int           n_out;
        logic [127:0] got;
        sent    = 1'b0;
        n_out   = 0;
        got     = '0;
        in_data = d;
        for (int c = 0; c < 80; c++) begin
            in_valid = !sent;
            #1;
            if (in_valid && in_ready) sent = 1'b1;
            if (out_valid && out_ready) begin
                n_out++;
                if (n_out == 1) got = out_data;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_sent"},  128'(sent),  128'(1));
        check({tag, "_count"}, 128'(n_out), 128'(1));
        check({tag, "_data"},  got, ref_encrypt(cur_key, d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           l1, l4, l8;
        logic [127:0] d1, d4, d8;
        int           sent, recv, cnt;
        logic         held_valid;
        logic [127:0] held_data;
        logic [127:0] exp;
        logic [255:0] key2, key3;
        logic         accepted;

        key_in    = '0;
        in_data   = '0;
        a_key_in  = '0;
        a_in_data = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data",  out_data,        128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_key_ready", 128'(key_ready), 128'(1));
        check("rst_in_ready",  128'(in_ready),  128'(0));
        @(negedge clk);

        // Known key, plaintext 0; key and block offered together while idle
        key_valid = 1'b1;
        key_in    = KAT_KEY;
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        check("tie_key_ready",   128'(key_ready), 128'(1));
        check("tie_in_ready_c0", 128'(in_ready),  128'(0));
        @(negedge clk);
        key_valid = 1'b0;
        cur_key   = KAT_KEY;
        #1;
        check("tie_in_ready_c1", 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("kat_latency_rps2", 128'(lat), 128'(17));
        check("kat_data_rps2",    out_data,  ref_encrypt(KAT_KEY, '0));
        @(negedge clk);

        // Same vector through RPS = 1, 4, 8
        a_key_valid = 1'b1;
        a_key_in    = KAT_KEY;
        #1;
        check("aux_key_ready", 128'({a1_key_ready, a4_key_ready, a8_key_ready}), 128'(3'b111));
        @(negedge clk);
        a_key_valid = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = '0;
        #1;
        check("aux_in_ready", 128'({a1_in_ready, a4_in_ready, a8_in_ready}), 128'(3'b111));
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 1;
        l1 = 0; l4 = 0; l8 = 0;
        d1 = '0; d4 = '0; d8 = '0;
        while (lat < 60 && (l1 == 0 || l4 == 0 || l8 == 0)) begin
            if (a1_out_valid && l1 == 0) begin l1 = lat; d1 = a1_out_data; end
            if (a4_out_valid && l4 == 0) begin l4 = lat; d4 = a4_out_data; end
            if (a8_out_valid && l8 == 0) begin l8 = lat; d8 = a8_out_data; end
            @(negedge clk);
            lat++;
        end
        check("kat_latency_rps1", 128'(l1), 128'(33));
        check("kat_latency_rps4", 128'(l4), 128'(9));
        check("kat_latency_rps8", 128'(l8), 128'(5));
        check("kat_data_rps1", d1, ref_encrypt(KAT_KEY, '0));
        check("kat_data_rps4", d4, ref_encrypt(KAT_KEY, '0));
        check("kat_data_rps8", d8, ref_encrypt(KAT_KEY, '0));
        repeat (3) @(negedge clk);
        #1;
        check("aux_drained", 128'({a1_busy, a4_busy, a8_busy}), 128'(0));
        @(negedge clk);

        // 40 back-to-back blocks under random backpressure
        load_key({$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom});
        sent = 0;
        recv = 0;
        held_valid = 1'b0;
        held_data  = '0;
        for (int c = 0; c < 3000 && recv < 40; c++) begin
            if (held_valid) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_hold",  out_data,        held_data);
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 40);
            in_data   = 128'(sent);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 128'(1), 128'(0));
                end else begin
                    exp = exp_q.pop_front();
                    check("stream_data", out_data, exp);
                end
                recv++;
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_encrypt(cur_key, 128'(sent)));
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_count", 128'(recv),         128'(40));
        check("stream_empty", 128'(exp_q.size()), 128'(0));

        // Key offered while blocks are stalled in flight
        out_ready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 128'(100 + cnt);
            #1;
            if (in_ready) begin
                exp_q.push_back(ref_encrypt(cur_key, 128'(100 + cnt)));
                cnt++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        key2      = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        key_in    = key2;
        for (int c = 0; c < 25; c++) begin
            #1;
            check("key_blocked", 128'(key_ready), 128'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        recv      = 0;
        accepted  = 1'b0;
        for (int c = 0; c < 200 && !accepted; c++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected", 128'(1), 128'(0));
                end else begin
                    exp = exp_q.pop_front();
                    check("drain_old_key", out_data, exp);
                end
                recv++;
            end
            if (key_ready) begin
                accepted = 1'b1;
                check("key_after_drain", 128'(exp_q.size()), 128'(0));
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("key_accepted", 128'(accepted), 128'(1));
        check("drain_count",  128'(recv),     128'(5));
        cur_key = key2;
        send_and_check(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, "new_key");

        // Reset with 10 blocks in flight
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 128'(300 + cnt);
            #1;
            if (in_ready) cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_busy",      128'(busy),      128'(0));
        check("midrst_in_ready",  128'(in_ready),  128'(0));
        check("midrst_key_ready", 128'(key_ready), 128'(1));
        @(negedge clk);
        key3 = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
        load_key(key3);
        send_and_check(128'({$urandom, $urandom, $urandom, $urandom}), "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
